// File: rtl/instruction_issue_buffer_pkg.sv
// rtl/instruction_issue_buffer_pkg.sv - shared types and constants for the instruction issue buffer
//
// Contents:
//   ENTRY_PC_W / ENTRY_INST_W : field widths of a stored issue entry
//   INST_BYTES                : byte distance between consecutive fetched instructions
//   issue_entry_t             : one buffered instruction {pc, inst}

package instruction_issue_buffer_pkg;

  localparam int ENTRY_PC_W   = 32;
  localparam int ENTRY_INST_W = 32;
  localparam int INST_BYTES   = 4;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0]   pc;
    logic [ENTRY_INST_W-1:0] inst;
  } issue_entry_t;

endpackage

// File: rtl/instruction_issue_buffer.sv
// rtl/instruction_issue_buffer.sv - circular FIFO between fetch and the dual-issue scheduler
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   flush               : discard every entry; wins over same-cycle push and retire
//   fetch_valid/count   : fetch offers 1 or 2 instructions this cycle
//   fetch_pc/inst0/inst1: first PC and the two instruction words (second PC = fetch_pc + 4)
//   fetch_ready         : at least two free entries (current occupancy only)
//   issue0_* / issue1_* : oldest and second-oldest entries, read combinationally from storage
//   issue_count         : entries consumed by the scheduler this cycle (clamped to occupancy)
//   occupancy           : current number of held entries

module instruction_issue_buffer
  import instruction_issue_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int INST_W = ENTRY_INST_W,
  parameter int PC_W   = ENTRY_PC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       fetch_valid,
  input  logic [1:0]                 fetch_count,
  input  logic [PC_W-1:0]            fetch_pc,
  input  logic [INST_W-1:0]          fetch_inst0,
  input  logic [INST_W-1:0]          fetch_inst1,
  output logic                       fetch_ready,
  output logic                       issue0_valid,
  output logic [PC_W-1:0]            issue0_pc,
  output logic [INST_W-1:0]          issue0_inst,
  output logic                       issue1_valid,
  output logic [PC_W-1:0]            issue1_pc,
  output logic [INST_W-1:0]          issue1_inst,
  input  logic [1:0]                 issue_count,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  // Storage uses the shared entry type, so the width parameters must match it.
  if (PC_W != ENTRY_PC_W || INST_W != ENTRY_INST_W) begin : g_width_check
    $error("instruction_issue_buffer: PC_W/INST_W must match issue_entry_t field widths");
  end

  issue_entry_t mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;

  logic [1:0]       push_n;
  logic [1:0]       retire_req;
  logic [1:0]       retire_n;
  logic             do_push;

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  // Ready looks only at the registered count, never at this cycle's retire,
  // so the scheduler's issue decision does not feed back into fetch.
  assign fetch_ready = (occupancy <= OCC_W'(DEPTH - 2));
  assign do_push     = fetch_valid && fetch_ready && !flush;

  always_comb begin
    push_n     = 2'd0;
    retire_req = 2'd0;
    retire_n   = 2'd0;
    // An illegal count of 3 is treated as 2 so two free entries always suffice.
    if (fetch_valid && fetch_ready) begin
      push_n = fetch_count[1] ? 2'd2 : {1'b0, fetch_count[0]};
    end
    retire_req = issue_count[1] ? 2'd2 : {1'b0, issue_count[0]};
    // Consuming more than is held is clamped to what is actually present.
    if (occupancy < OCC_W'(retire_req)) begin
      retire_n = occupancy[1:0];
    end else begin
      retire_n = retire_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      head      <= head + PTR_W'(retire_n);
      tail      <= tail + PTR_W'(push_n);
      occupancy <= occupancy + OCC_W'(push_n) - OCC_W'(retire_n);
    end
  end

  // Entry contents need no reset: validity is carried entirely by occupancy.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= '{pc: fetch_pc, inst: fetch_inst0};
      if (push_n == 2'd2) begin
        mem[tail_p1] <= '{pc: fetch_pc + PC_W'(INST_BYTES), inst: fetch_inst1};
      end
    end
  end

  assign issue0_valid = (occupancy >= OCC_W'(1));
  assign issue1_valid = (occupancy >= OCC_W'(2));
  assign issue0_pc    = mem[head].pc;
  assign issue0_inst  = mem[head].inst;
  assign issue1_pc    = mem[head_p1].pc;
  assign issue1_inst  = mem[head_p1].inst;

  a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= OCC_W'(DEPTH));

  a_fetch_count_legal : assert property (@(posedge clk) disable iff (!rst_n)
    fetch_valid |-> (fetch_count == 2'd1 || fetch_count == 2'd2));

endmodule

// File: tb/tb_instruction_issue_buffer.sv
// tb/tb_instruction_issue_buffer.sv - directed self-checking bench for instruction_issue_buffer

module tb_instruction_issue_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        fetch_valid;
  logic [1:0]  fetch_count;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst0;
  logic [31:0] fetch_inst1;
  logic        fetch_ready;
  logic        issue0_valid;
  logic [31:0] issue0_pc;
  logic [31:0] issue0_inst;
  logic        issue1_valid;
  logic [31:0] issue1_pc;
  logic [31:0] issue1_inst;
  logic [1:0]  issue_count;
  logic [3:0]  occupancy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instruction_issue_buffer #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_count(fetch_count), .fetch_pc(fetch_pc),
    .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1), .fetch_ready(fetch_ready),
    .issue0_valid(issue0_valid), .issue0_pc(issue0_pc), .issue0_inst(issue0_inst),
    .issue1_valid(issue1_valid), .issue1_pc(issue1_pc), .issue1_inst(issue1_inst),
    .issue_count(issue_count), .occupancy(occupancy)
  );

  // Over-issue is legal for the buffer (it clamps) but noted as a scheduler protocol slip.
  always @(negedge clk) begin
    if (rst_n && !flush && issue_count == 2'd2 && !issue1_valid)
      $display("protocol warning: issue_count=2 with issue1_valid=0 at %0t", $time);
  end

  task automatic set_idle();
    fetch_valid = 1'b0; fetch_count = 2'd0; fetch_pc = '0;
    fetch_inst0 = '0; fetch_inst1 = '0; issue_count = 2'd0; flush = 1'b0;
  endtask

  // Drive one cycle of stimulus; returns 1 time unit after the capturing edge.
  task automatic apply(input logic fv, input logic [1:0] fc, input logic [31:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] ic, input logic fl);
    fetch_valid = fv; fetch_count = fc; fetch_pc = pc;
    fetch_inst0 = i0; fetch_inst1 = i1; issue_count = ic; flush = fl;
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_cmp++; if (issue0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_v0 got %b want 0", issue0_valid); end
    n_cmp++; if (issue1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_v1 got %b want 0", issue1_valid); end
    n_cmp++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", fetch_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_push_basic();
    apply(1'b1, 2'd2, 32'h0040_0000, 32'h2408_0001, 32'h2409_0002, 2'd0, 1'b0);
    n_cmp++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL push_occ got %0d want 2", occupancy); end
    n_cmp++; if (issue0_valid !== 1'b1) begin n_fail++; $display("FAIL push_v0 got %b want 1", issue0_valid); end
    n_cmp++; if (issue1_valid !== 1'b1) begin n_fail++; $display("FAIL push_v1 got %b want 1", issue1_valid); end
    n_cmp++; if (issue0_pc !== 32'h0040_0000) begin n_fail++; $display("FAIL push_pc0 got %h want 00400000", issue0_pc); end
    n_cmp++; if (issue0_inst !== 32'h2408_0001) begin n_fail++; $display("FAIL push_inst0 got %h want 24080001", issue0_inst); end
    n_cmp++; if (issue1_pc !== 32'h0040_0004) begin n_fail++; $display("FAIL push_pc1 got %h want 00400004", issue1_pc); end
    n_cmp++; if (issue1_inst !== 32'h2409_0002) begin n_fail++; $display("FAIL push_inst1 got %h want 24090002", issue1_inst); end
  endtask

  task automatic test_fill();
    apply(1'b0, 2'd0, '0, '0, '0, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++)
      apply(1'b1, 2'd2, 32'h1000 + 32'(8 * k), 32'hA000_0000 + 32'(2 * k), 32'hA000_0001 + 32'(2 * k), 2'd0, 1'b0);
    n_cmp++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL fill_occ got %0d want 8", occupancy); end
    n_cmp++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %b want 0", fetch_ready); end
    // Tail has wrapped onto the head entry; an accepted fifth offer would overwrite slot 0.
    apply(1'b1, 2'd2, 32'h2000, 32'hDEAD_0000, 32'hDEAD_0001, 2'd0, 1'b0);
    n_cmp++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL fill_extra_occ got %0d want 8", occupancy); end
    n_cmp++; if (issue0_pc !== 32'h1000) begin n_fail++; $display("FAIL fill_extra_pc0 got %h want 00001000", issue0_pc); end
    n_cmp++; if (issue0_inst !== 32'hA000_0000) begin n_fail++; $display("FAIL fill_extra_inst0 got %h want a0000000", issue0_inst); end
    apply(1'b0, 2'd0, '0, '0, '0, 2'd2, 1'b0);
    n_cmp++; if (occupancy !== 4'd6) begin n_fail++; $display("FAIL fill_ret_occ got %0d want 6", occupancy); end
    n_cmp++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ret_ready got %b want 1", fetch_ready); end
    n_cmp++; if (issue0_pc !== 32'h1008) begin n_fail++; $display("FAIL fill_ret_pc0 got %h want 00001008", issue0_pc); end
    apply(1'b0, 2'd0, '0, '0, '0, 2'd2, 1'b0);
    apply(1'b0, 2'd0, '0, '0, '0, 2'd2, 1'b0);
    n_cmp++; if (issue0_pc !== 32'h1018) begin n_fail++; $display("FAIL fill_tail_pc0 got %h want 00001018", issue0_pc); end
    n_cmp++; if (issue1_pc !== 32'h101C) begin n_fail++; $display("FAIL fill_tail_pc1 got %h want 0000101c", issue1_pc); end
    n_cmp++; if (issue1_inst !== 32'hA000_0007) begin n_fail++; $display("FAIL fill_tail_inst1 got %h want a0000007", issue1_inst); end
  endtask

  task automatic test_ready_no_credit();
    apply(1'b0, 2'd0, '0, '0, '0, 2'd0, 1'b1);
    apply(1'b1, 2'd2, 32'h3000, 32'h1, 32'h2, 2'd0, 1'b0);
    apply(1'b1, 2'd2, 32'h3008, 32'h3, 32'h4, 2'd0, 1'b0);
    apply(1'b1, 2'd2, 32'h3010, 32'h5, 32'h6, 2'd0, 1'b0);
    apply(1'b1, 2'd1, 32'h3018, 32'h7, 32'h0, 2'd0, 1'b0);
    n_cmp++; if (occupancy !== 4'd7) begin n_fail++; $display("FAIL nc_occ7 got %0d want 7", occupancy); end
    n_cmp++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL nc_ready got %b want 0", fetch_ready); end
    apply(1'b1, 2'd2, 32'h4000, 32'hBAD0, 32'hBAD1, 2'd2, 1'b0);
    n_cmp++; if (occupancy !== 4'd5) begin n_fail++; $display("FAIL nc_occ5 got %0d want 5", occupancy); end
    n_cmp++; if (issue0_pc !== 32'h3008) begin n_fail++; $display("FAIL nc_pc0 got %h want 00003008", issue0_pc); end
    n_cmp++; if (issue1_inst !== 32'h4) begin n_fail++; $display("FAIL nc_inst1 got %h want 00000004", issue1_inst); end
  endtask

  task automatic test_wrap();
    apply(1'b0, 2'd0, '0, '0, '0, 2'd0, 1'b1);
    for (int k = 0; k < 3; k++)
      apply(1'b1, 2'd2, 32'h5000 + 32'(8 * k), '0, '0, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++)
      apply(1'b0, 2'd0, '0, '0, '0, 2'd2, 1'b0);
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL wrap_empty got %0d want 0", occupancy); end
    apply(1'b1, 2'd2, 32'h6000, 32'h6000, 32'h6004, 2'd0, 1'b0);
    n_cmp++; if (issue1_pc !== 32'h6004) begin n_fail++; $display("FAIL wrap_start_pc1 got %h want 00006004", issue1_pc); end
    for (int k = 0; k < 10; k++) begin
      apply(1'b1, 2'd2, 32'h6000 + 32'(8 * (k + 1)), 32'h6000 + 32'(8 * (k + 1)),
            32'h6004 + 32'(8 * (k + 1)), 2'd2, 1'b0);
      n_cmp++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL wrap_occ[%0d] got %0d want 2", k, occupancy); end
      n_cmp++; if (issue0_pc !== 32'h6000 + 32'(8 * (k + 1))) begin n_fail++; $display("FAIL wrap_pc0[%0d] got %h want %h", k, issue0_pc, 32'h6000 + 32'(8 * (k + 1))); end
      n_cmp++; if (issue1_inst !== 32'h6004 + 32'(8 * (k + 1))) begin n_fail++; $display("FAIL wrap_inst1[%0d] got %h want %h", k, issue1_inst, 32'h6004 + 32'(8 * (k + 1))); end
    end
  endtask

  task automatic test_clamp();
    apply(1'b0, 2'd0, '0, '0, '0, 2'd0, 1'b1);
    apply(1'b1, 2'd1, 32'h7000, 32'h7, 32'h0, 2'd0, 1'b0);
    n_cmp++; if (issue1_valid !== 1'b0) begin n_fail++; $display("FAIL clamp_v1_pre got %b want 0", issue1_valid); end
    apply(1'b0, 2'd0, '0, '0, '0, 2'd2, 1'b0);
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL clamp_occ got %0d want 0", occupancy); end
    n_cmp++; if (issue0_valid !== 1'b0) begin n_fail++; $display("FAIL clamp_v0 got %b want 0", issue0_valid); end
    // If head moved by 2 instead of 1, slot 0 would show the second new entry.
    apply(1'b1, 2'd2, 32'h7100, 32'h71, 32'h72, 2'd0, 1'b0);
    n_cmp++; if (issue0_pc !== 32'h7100) begin n_fail++; $display("FAIL clamp_head_pc0 got %h want 00007100", issue0_pc); end
    n_cmp++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL clamp_occ2 got %0d want 2", occupancy); end
  endtask

  task automatic test_flush();
    apply(1'b0, 2'd0, '0, '0, '0, 2'd0, 1'b1);
    apply(1'b1, 2'd2, 32'h8000, '0, '0, 2'd0, 1'b0);
    apply(1'b1, 2'd2, 32'h8008, '0, '0, 2'd0, 1'b0);
    apply(1'b1, 2'd1, 32'h8010, '0, '0, 2'd0, 1'b0);
    n_cmp++; if (occupancy !== 4'd5) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 5", occupancy); end
    apply(1'b1, 2'd2, 32'h8100, 32'h1, 32'h2, 2'd1, 1'b1);
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", occupancy); end
    n_cmp++; if (issue0_valid !== 1'b0) begin n_fail++; $display("FAIL flush_v0 got %b want 0", issue0_valid); end
    n_cmp++; if (issue1_valid !== 1'b0) begin n_fail++; $display("FAIL flush_v1 got %b want 0", issue1_valid); end
    n_cmp++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", fetch_ready); end
    apply(1'b1, 2'd2, 32'h8800, 32'h88, 32'h89, 2'd0, 1'b0);
    n_cmp++; if (issue0_pc !== 32'h8800) begin n_fail++; $display("FAIL flush_after_pc0 got %h want 00008800", issue0_pc); end
    n_cmp++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL flush_after_occ got %0d want 2", occupancy); end
  endtask

  task automatic test_async_reset();
    apply(1'b1, 2'd2, 32'h9000, '0, '0, 2'd0, 1'b0);
    n_cmp++; if (occupancy !== 4'd4) begin n_fail++; $display("FAIL arst_pre_occ got %0d want 4", occupancy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL arst_occ got %0d want 0", occupancy); end
    n_cmp++; if (issue0_valid !== 1'b0) begin n_fail++; $display("FAIL arst_v0 got %b want 0", issue0_valid); end
    n_cmp++; if (issue1_valid !== 1'b0) begin n_fail++; $display("FAIL arst_v1 got %b want 0", issue1_valid); end
    n_cmp++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready got %b want 1", fetch_ready); end
    @(negedge clk); rst_n = 1'b1;
    apply(1'b1, 2'd1, 32'hA000, 32'hAA, 32'h0, 2'd0, 1'b0);
    n_cmp++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL arst_after_occ got %0d want 1", occupancy); end
    n_cmp++; if (issue0_pc !== 32'hA000) begin n_fail++; $display("FAIL arst_after_pc0 got %h want 0000a000", issue0_pc); end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_push_basic();
    test_fill();
    test_ready_no_credit();
    test_wrap();
    test_clamp();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
